// File: rtl/qar_gpio_pkg.sv
// Shared definitions for the qar_gpio peripheral: register map and bus FSM encoding.
package qar_gpio_pkg;

  localparam logic [7:0] GPIO_OUT     = 8'h00;
  localparam logic [7:0] GPIO_DIR     = 8'h04;
  localparam logic [7:0] GPIO_IN      = 8'h08;
  localparam logic [7:0] GPIO_IRQ_EN  = 8'h0C;
  localparam logic [7:0] GPIO_RISE_EN = 8'h10;
  localparam logic [7:0] GPIO_FALL_EN = 8'h14;
  localparam logic [7:0] GPIO_STATUS  = 8'h18;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/qar_gpio_filter.sv
// Pin synchroniser plus two-sample agree filter; emits one-cycle rise/fall pulses
// on every change of the filtered vector.
module qar_gpio_filter
  import qar_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] filt,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  samp_q;
  logic [WIDTH-1:0]                  sync_v;
  logic [WIDTH-1:0]                  upd;

  assign sync_v = sync_q[SYNC_STAGES-1];
  // A bit flips only when this sample matches the previous one and differs from filt.
  assign upd    = tick ? (~(sync_v ^ samp_q) & (sync_v ^ filt)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      samp_q <= '0;
      filt   <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
      if (tick) samp_q <= sync_v;
      filt <= filt ^ upd;
      rise <= upd & sync_v;
      fall <= upd & ~sync_v;
    end
  end

endmodule

// File: rtl/qar_gpio.sv
// Memory-mapped GPIO: output/direction registers, filtered inputs, edge status (W1C)
// and a registered level interrupt, behind a two-state request/ready bus.
module qar_gpio
  import qar_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FILTER_DIV  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [7:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic             bus_ready,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_dir,
  output logic             gpio_irq
);

  localparam int CW = (FILTER_DIV > 1) ? $clog2(FILTER_DIV) : 1;

  logic [CW-1:0]    pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] filt, rise, fall;
  logic [WIDTH-1:0] irq_en, rise_en, fall_en, status;
  logic [WIDTH-1:0] wval, clr, set;
  bus_state_t       state;
  logic             req_we;
  logic [7:0]       req_addr;
  logic [31:0]      req_wdata;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  assign tick = (pre_cnt == CW'(FILTER_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  qar_gpio_filter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_filt (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .pin_in (pin_in),
    .filt   (filt),
    .rise   (rise),
    .fall   (fall)
  );

  assign wr   = (state == BUS_RESP) && req_we;
  assign wval = WIDTH'(req_wdata);
  assign clr  = (wr && req_addr == GPIO_STATUS) ? wval : '0;
  assign set  = (rise & rise_en) | (fall & fall_en);

  always_comb begin
    rd_mux = '0;
    case (req_addr)
      GPIO_OUT:     rd_mux = 32'(gpio_out);
      GPIO_DIR:     rd_mux = 32'(gpio_dir);
      GPIO_IN:      rd_mux = 32'(filt);
      GPIO_IRQ_EN:  rd_mux = 32'(irq_en);
      GPIO_RISE_EN: rd_mux = 32'(rise_en);
      GPIO_FALL_EN: rd_mux = 32'(fall_en);
      GPIO_STATUS:  rd_mux = 32'(status);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BUS_IDLE;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          bus_ready <= 1'b0;
          bus_rdata <= '0;
          if (bus_valid) begin
            req_we    <= bus_we;
            req_addr  <= {bus_addr[7:2], 2'b00};
            req_wdata <= bus_wdata;
            state     <= BUS_RESP;
          end
        end
        BUS_RESP: begin
          bus_ready <= 1'b1;
          bus_rdata <= req_we ? 32'h0 : rd_mux;
          state     <= BUS_IDLE;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

  // New edges are OR-ed in after the clear so a same-cycle edge keeps its bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= '0;
      gpio_dir <= '0;
      irq_en   <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      gpio_irq <= 1'b0;
    end else begin
      if (wr) begin
        case (req_addr)
          GPIO_OUT:     gpio_out <= wval;
          GPIO_DIR:     gpio_dir <= wval;
          GPIO_IRQ_EN:  irq_en   <= wval;
          GPIO_RISE_EN: rise_en  <= wval;
          GPIO_FALL_EN: fall_en  <= wval;
          default: ;
        endcase
      end
      status   <= (status & ~clr) | set;
      gpio_irq <= |(status & irq_en);
    end
  end

endmodule

// File: tb/tb_qar_gpio.sv
// Self-checking bench for qar_gpio: register table, edge/filter/W1C/reset sequences,
// then randomized traffic against a register-level reference model.
`timescale 1ns/1ps
module tb_qar_gpio;
  localparam int W  = 32;
  localparam int FD = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_valid = 1'b0;
  logic          bus_we = 1'b0;
  logic [7:0]    bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_ready;
  logic [31:0]   bus_rdata;
  logic [W-1:0]  pin_in = '0;
  logic [W-1:0]  gpio_out, gpio_dir;
  logic          gpio_irq;

  always #5 clk = ~clk;

  qar_gpio #(.WIDTH(W), .FILTER_DIV(FD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .pin_in(pin_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .gpio_irq(gpio_irq)
  );

  int  total = 0;
  int  bad   = 0;
  time t_ready;
  time t_rise;

  // Timestamp of the internal rise pulse on pin 8, used only to locate the
  // edge that the W1C sweep is trying to collide with.
  always begin
    @(posedge clk); #1;
    if (dut.u_filt.rise[8]) t_rise = $time;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
    int lat = 0;
    bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    do begin @(posedge clk); #1; lat++; end while (!bus_ready && lat < 20);
    rd = bus_rdata;
    t_ready = $time;
    bus_valid = 1'b0;
    check("bus_latency", lat, 2);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, addr, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, addr, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic do_reset();
    pin_in = '0; bus_valid = 1'b0;
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  // Reference model: register contents and pin-level edge bookkeeping.
  logic [31:0] m_out, m_dir, m_ien, m_ren, m_fen, m_st, m_pin;

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    case (a[7:2])
      6'd0: return m_out;
      6'd1: return m_dir;
      6'd2: return m_pin;
      6'd3: return m_ien;
      6'd4: return m_ren;
      6'd5: return m_fen;
      6'd6: return m_st;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] r;
    int          hit;
    logic [31:0] exp_st;

    @(posedge clk); #1;
    do_reset();
    check("reset_outputs", {gpio_out[15:0], gpio_dir[13:0], gpio_irq, bus_ready}, 32'h0);
    check("reset_rdata", bus_rdata, 32'h0);

    tbl[0]  = '{1'b1, 8'h04, 32'h0000_00FF, 32'h0};
    tbl[1]  = '{1'b1, 8'h00, 32'h0000_005A, 32'h0};
    tbl[2]  = '{1'b0, 8'h04, 32'h0,         32'h0000_00FF};
    tbl[3]  = '{1'b0, 8'h00, 32'h0,         32'h0000_005A};
    tbl[4]  = '{1'b0, 8'h08, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{1'b0, 8'h08, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, 8'h1C, 32'h0,         32'h0};
    tbl[8]  = '{1'b0, 8'h07, 32'h0,         32'h0000_00FF};
    tbl[9]  = '{1'b0, 8'h18, 32'h0,         32'h0};
    tbl[10] = '{1'b1, 8'h40, 32'hDEAD_BEEF, 32'h0};
    tbl[11] = '{1'b0, 8'h00, 32'h0,         32'h0000_005A};
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, r);
      if (!tbl[i].we) check($sformatf("tbl_rd%0d", i), r, tbl[i].exp);
    end
    wait_clks(1);
    check("rdata_idle_zero", bus_rdata, 32'h0);
    check("gpio_dir", gpio_dir, 32'h0000_00FF);
    check("gpio_out", gpio_out, 32'h0000_005A);

    // Rising edge on pin 8 -> status + irq; W1C drops irq one clock later.
    wr(8'h0C, 32'h100);
    wr(8'h10, 32'h100);
    pin_in[8] = 1'b1;
    wait_clks(100);
    rd_chk("irq_status", 8'h18, 32'h100);
    check("irq_high", gpio_irq, 1'b1);
    wr(8'h18, 32'h100);
    check("irq_lag", gpio_irq, 1'b1);
    wait_clks(1);
    check("irq_cleared", gpio_irq, 1'b0);
    rd_chk("status_cleared", 8'h18, 32'h0);

    // Glitch filter on pin 3.
    wr(8'h0C, 32'h0);
    wr(8'h10, 32'h8);
    pin_in[3] = 1'b1; wait_clks(2); pin_in[3] = 1'b0;
    wait_clks(30);
    rd_chk("glitch_rejected", 8'h18, 32'h0);
    pin_in[3] = 1'b1; wait_clks(2 * FD); pin_in[3] = 1'b0;
    wait_clks(30);
    rd_chk("pulse_captured", 8'h18, 32'h8);
    rd_chk("in_after_pulse", 8'h08, 32'h100);
    wr(8'h18, 32'hFFFF_FFFF);

    // Fall-only enable on pin 0.
    wr(8'h10, 32'h0);
    wr(8'h14, 32'h1);
    pin_in[0] = 1'b1; wait_clks(30);
    rd_chk("fall_no_rise", 8'h18, 32'h0);
    rd_chk("in_pin0_high", 8'h08, 32'h101);
    pin_in[0] = 1'b0; wait_clks(30);
    rd_chk("fall_set", 8'h18, 32'h1);
    wr(8'h18, 32'h1);

    // Sweep W1C timing across the pin-8 rise; the coincident case must keep the bit.
    wr(8'h14, 32'h0);
    wr(8'h10, 32'h100);
    hit = 0;
    for (int d = 0; d < 15; d++) begin
      pin_in[8] = 1'b0;
      wait_clks(30);
      wr(8'h18, 32'hFFFF_FFFF);
      t_rise = 0;
      pin_in[8] = 1'b1;
      wait_clks(d);
      wr(8'h18, 32'h100);
      wait_clks(30);
      exp_st = (t_rise != 0 && t_ready <= t_rise + 10) ? 32'h100 : 32'h0;
      if (t_rise != 0 && t_ready == t_rise + 10) hit = 1;
      rd_chk($sformatf("w1c_sweep_d%0d", d), 8'h18, exp_st);
    end
    check("w1c_coincidence_seen", hit, 1);

    // Reset during RESP of a write, then during the ready cycle.
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 8'h00; bus_wdata = 32'hFFFF;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_resp_ready", bus_ready, 1'b0);
    check("rst_resp_out", gpio_out, 32'h0);
    bus_valid = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(3);
    check("rst_resp_out_after", gpio_out, 32'h0);
    wr(8'h00, 32'h33);
    #2 rst = 1'b1; #1;
    check("rst_async_ready", bus_ready, 1'b0);
    check("rst_async_rdata", bus_rdata, 32'h0);
    wait_clks(2);

    // Randomized traffic against the reference model.
    do_reset();
    m_out = 0; m_dir = 0; m_ien = 0; m_ren = 0; m_fen = 0; m_st = 0; m_pin = 0;
    for (int it = 0; it < 80; it++) begin
      int          op;
      logic [7:0]  a;
      logic [31:0] d, np;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          a = {2'b00, 4'($urandom_range(0, 9)), 2'($urandom_range(0, 3))};
          d = $urandom;
          wr(a, d);
          case (a[7:2])
            6'd0: m_out = d;
            6'd1: m_dir = d;
            6'd3: m_ien = d;
            6'd4: m_ren = d;
            6'd5: m_fen = d;
            6'd6: m_st  = m_st & ~d;
            default: ;
          endcase
          wait_clks(1);
          check("rnd_out", gpio_out, m_out);
          check("rnd_dir", gpio_dir, m_dir);
          check("rnd_irq_wr", gpio_irq, 32'(|(m_st & m_ien)));
        end
        1: begin
          a = 8'($urandom);
          rd_chk($sformatf("rnd_rd_%h", a), a, exp_read(a));
        end
        2: begin
          np = $urandom;
          pin_in = np;
          wait_clks(30);
          m_st  = m_st | (~m_pin & np & m_ren) | (m_pin & ~np & m_fen);
          m_pin = np;
          check("rnd_irq_pin", gpio_irq, 32'(|(m_st & m_ien)));
        end
        default: rd_chk("rnd_status", 8'h18, m_st);
      endcase
    end
    rd_chk("rnd_in_final", 8'h08, m_pin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
